// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for a shared tristate net: one-hot grant/oe,
// an enforced all-off turnaround gap between owners, and a bounded tenure under contention.
module tri_bus_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N-1:0]                          req,
    output logic [N-1:0]                          grant,
    output logic [N-1:0]                          oe,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  owner,
    output logic                                  busy,
    output logic                                  timeout
);

    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [N-1:0]  ONE_HOT0  = N'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN  = 2'd1;
    localparam logic [1:0] TURN = 2'd2;

    logic [1:0]    state, stateNext;
    logic [OW-1:0] last, lastNext;
    logic [HW-1:0] holdCnt, holdNext;
    logic [TW-1:0] turnCnt, turnNext;
    logic [N-1:0]  grantNext;
    logic [OW-1:0] ownerNext;
    logic          busyNext;
    logic          timeoutNext;

    logic          arbFound;
    logic [OW-1:0] arbIdx;
    logic [OW-1:0] cand;
    logic          ownerReq;
    logic          othersPending;

    // First requester after the previous owner, wrapping modulo N.
    always_comb begin
        arbFound = 1'b0;
        arbIdx   = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = OW'((32'(last) + k) % N);
            if (!arbFound && req[cand]) begin
                arbFound = 1'b1;
                arbIdx   = cand;
            end
        end
    end

    assign ownerReq      = req[owner];
    assign othersPending = |(req & ~grant);

    always_comb begin
        stateNext   = state;
        lastNext    = last;
        holdNext    = holdCnt;
        turnNext    = turnCnt;
        grantNext   = grant;
        ownerNext   = owner;
        busyNext    = busy;
        timeoutNext = 1'b0;

        case (state)
            IDLE: begin
                if (arbFound) begin
                    stateNext = OWN;
                    grantNext = ONE_HOT0 << arbIdx;
                    ownerNext = arbIdx;
                    busyNext  = 1'b1;
                    holdNext  = '0;
                end
            end
            OWN: begin
                if (!ownerReq || (holdCnt == HOLD_LAST && othersPending)) begin
                    stateNext   = TURN;
                    grantNext   = '0;
                    ownerNext   = '0;
                    busyNext    = 1'b0;
                    lastNext    = owner;
                    turnNext    = '0;
                    // Still requesting means the hold limit forced it off.
                    timeoutNext = ownerReq;
                end else if (holdCnt != HOLD_LAST) begin
                    holdNext = holdCnt + HW'(1);
                end
            end
            TURN: begin
                if (turnCnt == TURN_LAST) begin
                    if (arbFound) begin
                        stateNext = OWN;
                        grantNext = ONE_HOT0 << arbIdx;
                        ownerNext = arbIdx;
                        busyNext  = 1'b1;
                        holdNext  = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    turnNext = turnCnt + TW'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
                ownerNext = '0;
                busyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= OW'(N - 1);
            holdCnt <= '0;
            turnCnt <= '0;
            grant   <= '0;
            oe      <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= stateNext;
            last    <= lastNext;
            holdCnt <= holdNext;
            turnCnt <= turnNext;
            grant   <= grantNext;
            oe      <= grantNext;
            owner   <= ownerNext;
            busy    <= busyNext;
            timeout <= timeoutNext;
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: a tenure/gap reference model queues expected
// outputs per cycle; a monitor pops and compares, and checks bus-contention invariants.
module tb_tri_bus_arbiter;

    localparam int N          = 4;
    localparam int MAX_HOLD   = 8;
    localparam int TURNAROUND = 1;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       timeout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int assertCount = 0;
    int failCount   = 0;
    exp_t expQ[$];

    // Reference model: who owns the bus, for how long, and how much gap remains.
    int   mOwner = -1;
    int   mTen   = 0;
    int   mGap   = 0;
    int   mLast  = N - 1;
    logic mTimeout = 1'b0;

    tri_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .oe(oe),
        .owner(owner), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        assertCount++;
        if (act != want) begin
            failCount++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic modelStep(input logic r, input logic [3:0] rq);
        exp_t e;
        logic [3:0] mine;
        int i;
        mTimeout = 1'b0;
        if (r) begin
            mOwner = -1;
            mGap   = 0;
            mLast  = N - 1;
        end else if (mOwner >= 0) begin
            mine = 4'b0001 << mOwner;
            if (!rq[mOwner]) begin
                mLast  = mOwner;
                mOwner = -1;
                mGap   = TURNAROUND;
            end else if (mTen >= MAX_HOLD && (rq & ~mine) != 4'b0000) begin
                mLast    = mOwner;
                mOwner   = -1;
                mGap     = TURNAROUND;
                mTimeout = 1'b1;
            end else begin
                mTen++;
            end
        end else if (mGap > 1) begin
            mGap--;
        end else begin
            mGap = 0;
            for (int k = 1; k <= N; k++) begin
                i = (mLast + k) % N;
                if (mOwner < 0 && rq[i]) begin
                    mOwner = i;
                    mTen   = 1;
                end
            end
        end
        e.grant   = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        e.owner   = (mOwner >= 0) ? 2'(mOwner) : 2'd0;
        e.busy    = (mOwner >= 0);
        e.timeout = mTimeout;
        expQ.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst = r;
            req = rq;
            modelStep(r, rq);
        end
    endtask

    // Monitor: one expected entry per clock edge after stimulus starts.
    initial begin
        exp_t e;
        logic [3:0] prevOe;
        prevOe = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("grant", int'(grant), int'(e.grant));
                check("owner", int'(owner), int'(e.owner));
                check("busy", int'(busy), int'(e.busy));
                check("timeout", int'(timeout), int'(e.timeout));
                check("oe_eq_grant", int'(oe), int'(grant));
                check("oe_popcount_le1", int'($countones(oe) <= 1), 1);
                check("oe_no_direct_handoff",
                      int'(!(prevOe != 4'b0000 && oe != 4'b0000 && oe != prevOe)), 1);
                prevOe = oe;
            end
        end
    end

    initial begin
        logic [3:0] rq;
        logic       r;
        int guard;
        rst = 1'b1;
        req = 4'b0000;

        // Reset held with all requesting, then round robin under full load.
        drive(1'b1, 4'b1111, 2);
        drive(1'b0, 4'b1111, 40);

        // Single long requester with nobody else pending.
        drive(1'b1, 4'b0000, 1);
        drive(1'b0, 4'b0100, 20);
        drive(1'b0, 4'b0000, 3);

        // Voluntary handoff from owner 0 to requester 2.
        drive(1'b1, 4'b0000, 1);
        drive(1'b0, 4'b0101, 3);
        drive(1'b0, 4'b0100, 5);
        drive(1'b0, 4'b0000, 3);

        // Reset in the middle of a tenure.
        drive(1'b0, 4'b0010, 4);
        drive(1'b1, 4'b0010, 1);
        drive(1'b0, 4'b0011, 5);
        drive(1'b0, 4'b0000, 2);

        // Random contention run.
        rq = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 5) == 0)
                rq[$urandom_range(0, 3)] = ~rq[$urandom_range(0, 3)];
            if ($urandom_range(0, 40) == 0)
                rq = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 999) == 0);
            drive(r, rq, 1);
        end
        drive(1'b0, 4'b0000, 3);

        guard = 0;
        while (expQ.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
